// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared encodings for the forwarding/hazard unit: forward-select codes and FSM states.
package fwd_hazard_ctrl_pkg;

   localparam logic [1:0] FWD_NONE  = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_LU_STALL = 1'b1
   } hazard_state_e;

endpackage

// File: rtl/fwd_src_sel.sv
// Forward select for one EX-stage source operand; EX/MEM result wins over MEM/WB.
// FWD_ZERO_REG_EN: register 0 is hardwired zero and never forwards.
module fwd_src_sel
   import fwd_hazard_ctrl_pkg::*;
#(
   parameter int AW = 4
) (
   input  logic [AW-1:0] src_i,
   input  logic          reg_write_en_exmem_i,
   input  logic [AW-1:0] rd_exmem_i,
   input  logic          reg_write_en_memwb_i,
   input  logic [AW-1:0] rd_memwb_i,
   output logic [1:0]    sel_o
);

   logic exmem_hit;
   logic memwb_hit;

   always_comb begin
      exmem_hit = reg_write_en_exmem_i && (rd_exmem_i == src_i);
      memwb_hit = reg_write_en_memwb_i && (rd_memwb_i == src_i);
`ifdef FWD_ZERO_REG_EN
      exmem_hit = exmem_hit && (src_i != '0);
      memwb_hit = memwb_hit && (src_i != '0);
`endif
      if (exmem_hit)      sel_o = FWD_EXMEM;
      else if (memwb_hit) sel_o = FWD_MEMWB;
      else                sel_o = FWD_NONE;
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Pipeline forwarding selects plus load-use stall FSM with mem_wait freeze.
// FWD_ZERO_REG_EN: register 0 is hardwired zero (no forwarding, no load-use hazard on it).
module fwd_hazard_ctrl
   import fwd_hazard_ctrl_pkg::*;
#(
   parameter int AW       = 4,
   parameter int NUM_SRC  = 2,
   parameter int LOAD_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_SRC*AW-1:0] src_ifid,
   input  logic [NUM_SRC-1:0]    src_used_ifid,
   input  logic [NUM_SRC*AW-1:0] src_idex,
   input  logic                  mem_read_idex,
   input  logic                  reg_write_en_idex,
   input  logic [AW-1:0]         rd_idex,
   input  logic                  reg_write_en_exmem,
   input  logic [AW-1:0]         rd_exmem,
   input  logic                  reg_write_en_memwb,
   input  logic [AW-1:0]         rd_memwb,
   input  logic                  mem_wait,
   output logic [2*NUM_SRC-1:0]  forward_sel,
   output logic                  pc_write_en,
   output logic                  ifid_write_en,
   output logic                  idex_flush,
   output logic                  pipe_hold,
   output logic                  stall_active,
   output hazard_state_e         state_dbg
);

   localparam int CNT_W = (LOAD_LAT < 2) ? 1 : $clog2(LOAD_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   if (LOAD_LAT < 1) begin : g_bad_load_lat
      $error("fwd_hazard_ctrl: LOAD_LAT must be >= 1");
   end

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_src_sel #(.AW(AW)) u_sel (
         .src_i                (src_idex[i*AW +: AW]),
         .reg_write_en_exmem_i (reg_write_en_exmem),
         .rd_exmem_i           (rd_exmem),
         .reg_write_en_memwb_i (reg_write_en_memwb),
         .rd_memwb_i           (rd_memwb),
         .sel_o                (forward_sel[2*i +: 2])
      );
   end

   hazard_state_e    state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             lu_haz;
   logic             src_hit;

   always_comb begin
      src_hit = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (src_used_ifid[i] && (src_ifid[i*AW +: AW] == rd_idex)) src_hit = 1'b1;
      end
      lu_haz = mem_read_idex && reg_write_en_idex && src_hit;
`ifdef FWD_ZERO_REG_EN
      lu_haz = lu_haz && (rd_idex != '0);
`endif
   end

   // cnt counts the bubbles still owed after the one inserted on entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else if (!mem_wait) begin
         case (state_q)
            ST_RUN: begin
               if (lu_haz && (LOAD_LAT > 1)) begin
                  state_q <= ST_LU_STALL;
                  cnt_q   <= CNT_INIT;
               end
            end
            ST_LU_STALL: begin
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CNT_LAST) state_q <= ST_RUN;
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   always_comb begin
      pc_write_en   = 1'b1;
      ifid_write_en = 1'b1;
      idex_flush    = 1'b0;
      pipe_hold     = 1'b0;
      stall_active  = 1'b0;
      if (mem_wait) begin
         pc_write_en   = 1'b0;
         ifid_write_en = 1'b0;
         pipe_hold     = 1'b1;
         stall_active  = 1'b1;
      end else if ((state_q == ST_LU_STALL) || lu_haz) begin
         pc_write_en   = 1'b0;
         ifid_write_en = 1'b0;
         idex_flush    = 1'b1;
         stall_active  = 1'b1;
      end
   end

   assign state_dbg = state_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl with LOAD_LAT=3; honours FWD_ZERO_REG_EN when defined.
module tb_fwd_hazard_ctrl;
   import fwd_hazard_ctrl_pkg::*;

   localparam int AW       = 4;
   localparam int NUM_SRC  = 2;
   localparam int LOAD_LAT = 3;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NUM_SRC*AW-1:0] src_ifid;
   logic [NUM_SRC-1:0]    src_used_ifid;
   logic [NUM_SRC*AW-1:0] src_idex;
   logic                  mem_read_idex;
   logic                  reg_write_en_idex;
   logic [AW-1:0]         rd_idex;
   logic                  reg_write_en_exmem;
   logic [AW-1:0]         rd_exmem;
   logic                  reg_write_en_memwb;
   logic [AW-1:0]         rd_memwb;
   logic                  mem_wait;
   logic [2*NUM_SRC-1:0]  forward_sel;
   logic                  pc_write_en;
   logic                  ifid_write_en;
   logic                  idex_flush;
   logic                  pipe_hold;
   logic                  stall_active;
   hazard_state_e         state_dbg;

   int checks   = 0;
   int failures = 0;

   fwd_hazard_ctrl #(.AW(AW), .NUM_SRC(NUM_SRC), .LOAD_LAT(LOAD_LAT)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .src_ifid           (src_ifid),
      .src_used_ifid      (src_used_ifid),
      .src_idex           (src_idex),
      .mem_read_idex      (mem_read_idex),
      .reg_write_en_idex  (reg_write_en_idex),
      .rd_idex            (rd_idex),
      .reg_write_en_exmem (reg_write_en_exmem),
      .rd_exmem           (rd_exmem),
      .reg_write_en_memwb (reg_write_en_memwb),
      .rd_memwb           (rd_memwb),
      .mem_wait           (mem_wait),
      .forward_sel        (forward_sel),
      .pc_write_en        (pc_write_en),
      .ifid_write_en      (ifid_write_en),
      .idex_flush         (idex_flush),
      .pipe_hold          (pipe_hold),
      .stall_active       (stall_active),
      .state_dbg          (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic clear_inputs();
      src_ifid           = '0;
      src_used_ifid      = '0;
      src_idex           = '0;
      mem_read_idex      = 1'b0;
      reg_write_en_idex  = 1'b0;
      rd_idex            = '0;
      reg_write_en_exmem = 1'b0;
      rd_exmem           = '0;
      reg_write_en_memwb = 1'b0;
      rd_memwb           = '0;
      mem_wait           = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_load(input logic [AW-1:0] rd, input logic [NUM_SRC*AW-1:0] srcs,
                             input logic [NUM_SRC-1:0] used);
      mem_read_idex     = 1'b1;
      reg_write_en_idex = 1'b1;
      rd_idex           = rd;
      src_ifid          = srcs;
      src_used_ifid     = used;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      #12;
      checks++;
      if ({pc_write_en, ifid_write_en, idex_flush, pipe_hold, stall_active} !== 5'b11000) begin
         failures++;
         $display("FAIL reset_ctrl: got %b want 11000",
                  {pc_write_en, ifid_write_en, idex_flush, pipe_hold, stall_active});
      end
      checks++;
      if (state_dbg !== ST_RUN || forward_sel !== 4'b0000) begin
         failures++;
         $display("FAIL reset_state: state=%0d fsel=%b want 0 0000", state_dbg, forward_sel);
      end
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_forward();
      logic [NUM_SRC*AW-1:0] v_src [7] = '{8'h21, 8'h95, 8'h95, 8'h95, 8'h55, 8'h93, 8'hFF};
      logic                  v_wex [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [AW-1:0]         v_rex [7] = '{4'd1, 4'd5, 4'd5, 4'd5, 4'd5, 4'd9, 4'd15};
      logic                  v_wwb [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [AW-1:0]         v_rwb [7] = '{4'd2, 4'd5, 4'd5, 4'd9, 4'd5, 4'd3, 4'd15};
      logic [3:0]            v_exp [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b1001,
                                           4'b0101, 4'b0110, 4'b0101};
      for (int v = 0; v < 7; v++) begin
         src_idex           = v_src[v];
         reg_write_en_exmem = v_wex[v];
         rd_exmem           = v_rex[v];
         reg_write_en_memwb = v_wwb[v];
         rd_memwb           = v_rwb[v];
         @(negedge clk);
         checks++;
         if (forward_sel !== v_exp[v] || pc_write_en !== 1'b1 || stall_active !== 1'b0) begin
            failures++;
            $display("FAIL forward_vec%0d: fsel=%b pc=%b act=%b want %b 1 0",
                     v, forward_sel, pc_write_en, stall_active, v_exp[v]);
         end
         next_cycle();
      end
      clear_inputs();
   endtask

   task automatic test_load_use();
      logic          e_flush [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      hazard_state_e e_st    [4] = '{ST_RUN, ST_LU_STALL, ST_LU_STALL, ST_RUN};
      drive_load(4'd3, 8'h43, 2'b01);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (idex_flush !== e_flush[c] || pc_write_en !== !e_flush[c] ||
             ifid_write_en !== !e_flush[c] || stall_active !== e_flush[c] ||
             pipe_hold !== 1'b0 || state_dbg !== e_st[c]) begin
            failures++;
            $display("FAIL load_use_c%0d: flush=%b pc=%b ifid=%b act=%b hold=%b st=%0d want %b %b %b %b 0 %0d",
                     c, idex_flush, pc_write_en, ifid_write_en, stall_active, pipe_hold, state_dbg,
                     e_flush[c], !e_flush[c], !e_flush[c], e_flush[c], e_st[c]);
         end
         next_cycle();
         mem_read_idex     = 1'b0;
         reg_write_en_idex = 1'b0;
      end
      clear_inputs();
   endtask

   task automatic test_mem_wait_stall();
      logic          e_mw    [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic          e_flush [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic          e_pc    [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      hazard_state_e e_st    [6] = '{ST_RUN, ST_LU_STALL, ST_LU_STALL, ST_LU_STALL,
                                     ST_LU_STALL, ST_RUN};
      reg_write_en_exmem = 1'b1;
      rd_exmem           = 4'd6;
      src_idex           = 8'h06;
      drive_load(4'd3, 8'h43, 2'b01);
      for (int c = 0; c < 6; c++) begin
         mem_wait = e_mw[c];
         @(negedge clk);
         checks++;
         if (idex_flush !== e_flush[c] || pipe_hold !== e_mw[c] || pc_write_en !== e_pc[c] ||
             stall_active !== !e_pc[c] || state_dbg !== e_st[c] || forward_sel !== 4'b0001) begin
            failures++;
            $display("FAIL mem_wait_stall_c%0d: flush=%b hold=%b pc=%b act=%b st=%0d fsel=%b want %b %b %b %b %0d 0001",
                     c, idex_flush, pipe_hold, pc_write_en, stall_active, state_dbg, forward_sel,
                     e_flush[c], e_mw[c], e_pc[c], !e_pc[c], e_st[c]);
         end
         next_cycle();
         mem_read_idex     = 1'b0;
         reg_write_en_idex = 1'b0;
      end
      clear_inputs();
   endtask

   task automatic test_mem_wait_run();
      drive_load(4'd2, 8'h20, 2'b10);
      mem_wait = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if (pipe_hold !== 1'b1 || idex_flush !== 1'b0 || pc_write_en !== 1'b0 ||
             stall_active !== 1'b1 || state_dbg !== ST_RUN) begin
            failures++;
            $display("FAIL mem_wait_run_c%0d: hold=%b flush=%b pc=%b act=%b st=%0d want 1 0 0 1 0",
                     c, pipe_hold, idex_flush, pc_write_en, stall_active, state_dbg);
         end
         next_cycle();
      end
      mem_wait = 1'b0;
      @(negedge clk);
      checks++;
      if (idex_flush !== 1'b1 || pipe_hold !== 1'b0 || pc_write_en !== 1'b0) begin
         failures++;
         $display("FAIL mem_wait_release: flush=%b hold=%b pc=%b want 1 0 0",
                  idex_flush, pipe_hold, pc_write_en);
      end
      #1 clear_inputs();
      next_cycle();
   endtask

   task automatic test_reset_mid_stall();
      drive_load(4'd7, 8'h70, 2'b10);
      next_cycle();
      clear_inputs();
      @(negedge clk);
      checks++;
      if (state_dbg !== ST_LU_STALL || idex_flush !== 1'b1) begin
         failures++;
         $display("FAIL mid_stall_pre: st=%0d flush=%b want 1 1", state_dbg, idex_flush);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (pc_write_en !== 1'b1 || idex_flush !== 1'b0 || stall_active !== 1'b0 ||
          state_dbg !== ST_RUN) begin
         failures++;
         $display("FAIL mid_stall_async: pc=%b flush=%b act=%b st=%0d want 1 0 0 0",
                  pc_write_en, idex_flush, stall_active, state_dbg);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if (pc_write_en !== 1'b1 || idex_flush !== 1'b0 || state_dbg !== ST_RUN) begin
            failures++;
            $display("FAIL mid_stall_after_c%0d: pc=%b flush=%b st=%0d want 1 0 0",
                     c, pc_write_en, idex_flush, state_dbg);
         end
         next_cycle();
      end
   endtask

   task automatic test_zero_and_unused();
      logic [3:0] e_fsel;
      logic       e_zflush;
`ifdef FWD_ZERO_REG_EN
      e_fsel   = 4'b0000;
      e_zflush = 1'b0;
`else
      e_fsel   = 4'b0001;
      e_zflush = 1'b1;
`endif
      reg_write_en_exmem = 1'b1;
      rd_exmem           = 4'd0;
      src_idex           = 8'h40;
      drive_load(4'd0, 8'h80, 2'b01);
      @(negedge clk);
      checks++;
      if (forward_sel !== e_fsel) begin
         failures++;
         $display("FAIL zero_reg_fwd: fsel=%b want %b", forward_sel, e_fsel);
      end
      checks++;
      if (idex_flush !== e_zflush || pc_write_en !== !e_zflush) begin
         failures++;
         $display("FAIL zero_reg_lu: flush=%b pc=%b want %b %b",
                  idex_flush, pc_write_en, e_zflush, !e_zflush);
      end
      #1 clear_inputs();
      next_cycle();
      drive_load(4'd7, 8'h77, 2'b00);
      @(negedge clk);
      checks++;
      if (idex_flush !== 1'b0 || pc_write_en !== 1'b1 || stall_active !== 1'b0) begin
         failures++;
         $display("FAIL unused_src: flush=%b pc=%b act=%b want 0 1 0",
                  idex_flush, pc_write_en, stall_active);
      end
      #1 src_used_ifid = 2'b10;
      #1;
      checks++;
      if (idex_flush !== 1'b1 || pc_write_en !== 1'b0) begin
         failures++;
         $display("FAIL used_src1: flush=%b pc=%b want 1 0", idex_flush, pc_write_en);
      end
      #1 clear_inputs();
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_forward();
      test_load_use();
      test_mem_wait_stall();
      test_mem_wait_run();
      test_reset_mid_stall();
      test_zero_and_unused();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
